fetch_ctrl: RTL and testbench

Sequencer for the dual-issue instruction-fetch stage.
- Clears the fetch-stage instruction buffer, then streams a program image into it through a valid/ready handshake, driving the stage's load_en and instruction_in.
- Releases fetch, forwards hazard stalls and branch redirects, and detects end of program.
- Sits between the host/boot loader, the hazard unit and the fetch stage.

---
 rtl/fetch_ctrl_pkg.sv | 22 ++
 rtl/fetch_ctrl_if.sv | 38 +++
 rtl/fetch_ctrl_ldcnt.sv | 40 ++++
 rtl/fetch_ctrl.sv | 153 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the dual-issue fetch sequencer: state encoding,
// default widths/depth and a saturating increment helper.
package fetch_ctrl_pkg;

  localparam int ADDR_W_DEF   = 10;
  localparam int DATA_W_DEF   = 32;
  localparam int PROG_MAX_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  // Counter increment that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Loader handshake, hazard inputs and fetch-stage control bundled together.
// master = the sequencer, slave = loader / hazard unit / fetch stage side.
interface fetch_ctrl_if
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;

  logic              if_rst;
  logic              if_load_en;
  logic [DATA_W-1:0] if_instr;

  logic              hz_stall;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;

  logic              if_stall;
  logic              if_branch;
  logic [ADDR_W-1:0] if_pc_in;
  logic [ADDR_W-1:0] pc_cur;

  modport master (
    input  ld_valid, ld_data, ld_last, hz_stall, br_taken, br_target, pc_cur,
    output ld_ready, if_rst, if_load_en, if_instr, if_stall, if_branch, if_pc_in
  );

  modport slave (
    output ld_valid, ld_data, ld_last, hz_stall, br_taken, br_target, pc_cur,
    input  ld_ready, if_rst, if_load_en, if_instr, if_stall, if_branch, if_pc_in
  );

endinterface

// File: rtl/fetch_ctrl_ldcnt.sv
// Load counter for the fetch sequencer plus the two compares built on it:
// buffer-full (next word would overflow) and end-of-program.
module fetch_ctrl_ldcnt
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int PROG_MAX = PROG_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic [ADDR_W-1:0] pc_cur,
  output logic [ADDR_W:0]   prog_len,
  output logic              at_max,
  output logic              end_hit
);

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(PROG_MAX);

  logic [ADDR_W:0] pc_ahead;

  // Count words actually written into the buffer; cleared when a new load begins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      prog_len <= '0;
    else if (clr)
      prog_len <= '0;
    else if (inc)
      prog_len <= prog_len + 1'b1;
  end

  // Compare one bit wider than the PC so pc_cur+2 never wraps past the length
  always_comb begin
    pc_ahead = {1'b0, pc_cur} + (ADDR_W+1)'(2);
    at_max   = (prog_len == MAX_LEN);
    end_hit  = (pc_ahead >= prog_len);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: clears the instruction buffer, streams the program
// image in over a valid/ready handshake, then releases fetch while forwarding
// stalls and branch redirects until the end of the program is reached.
// Optional cycle counters are enabled with the macro FETCH_CTRL_PERF_EN.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int PROG_MAX = PROG_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  fetch_ctrl_if.master    bus,
  output logic [ADDR_W:0] prog_len,
  output logic            busy,
  output logic            done,
  output logic            err
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_run_cyc,
  output logic [31:0]     perf_stall_cyc
`endif
);

  state_t state;
  state_t state_nxt;

  logic start_ok;
  logic xfer;
  logic at_max;
  logic end_hit;
  logic ovf;
  logic wr;

  assign start_ok = start & ((state == ST_IDLE) | (state == ST_HALT));
  assign xfer     = (state == ST_LOAD) & bus.ld_valid;
  assign ovf      = xfer & at_max;
  assign wr       = xfer & ~at_max;
  assign busy     = (state == ST_CLEAR) | (state == ST_LOAD) | (state == ST_RUN);

  fetch_ctrl_ldcnt #(
    .ADDR_W   (ADDR_W),
    .PROG_MAX (PROG_MAX)
  ) u_ldcnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start_ok),
    .inc      (wr),
    .pc_cur   (bus.pc_cur),
    .prog_len (prog_len),
    .at_max   (at_max),
    .end_hit  (end_hit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state decode and fetch-stage output muxing
  always_comb begin
    state_nxt      = state;
    bus.ld_ready   = 1'b0;
    bus.if_rst     = 1'b0;
    bus.if_load_en = 1'b0;
    bus.if_instr   = '0;
    bus.if_stall   = 1'b0;
    bus.if_branch  = 1'b0;
    bus.if_pc_in   = '0;
    case (state)
      ST_IDLE: begin
        if (start_ok)
          state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        bus.if_rst   = 1'b1;
        bus.if_stall = 1'b1;
        state_nxt    = ST_LOAD;
      end
      ST_LOAD: begin
        bus.ld_ready = 1'b1;
        bus.if_stall = 1'b1;
        if (wr) begin
          bus.if_load_en = 1'b1;
          bus.if_instr   = bus.ld_data;
        end
        if (ovf)
          state_nxt = ST_HALT;
        else if (xfer && bus.ld_last)
          state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (bus.br_taken) begin
          bus.if_branch = 1'b1;
          bus.if_pc_in  = bus.br_target;
        end else begin
          bus.if_stall = bus.hz_stall;
          if (end_hit)
            state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        bus.if_stall = 1'b1;
        if (start_ok)
          state_nxt = ST_CLEAR;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Single-cycle done on the first cycle spent in HALT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      done <= 1'b0;
    else
      done <= (state_nxt == ST_HALT) && (state != ST_HALT);
  end

  // Sticky overflow flag, cleared only when a new load is started
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err <= 1'b0;
    else if (start_ok)
      err <= 1'b0;
    else if (ovf)
      err <= 1'b1;
  end

`ifdef FETCH_CTRL_PERF_EN
  // Saturating RUN-cycle and stalled-RUN-cycle counters, zeroed while clearing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_run_cyc   <= '0;
      perf_stall_cyc <= '0;
    end else if (state == ST_CLEAR) begin
      perf_run_cyc   <= '0;
      perf_stall_cyc <= '0;
    end else if (state == ST_RUN) begin
      perf_run_cyc <= sat_inc(perf_run_cyc);
      if (bus.if_stall)
        perf_stall_cyc <= sat_inc(perf_stall_cyc);
    end
  end
`else
  // Counters are not built; the sequencer behaves identically without them
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl with a shallow buffer (PROG_MAX = 8) so
// the overflow path is reachable in a few cycles.
module tb_fetch_ctrl;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int PMAX = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   prog_len;
  logic          busy;
  logic          done;
  logic          err;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0]   perf_run_cyc;
  logic [31:0]   perf_stall_cyc;
`endif

  int checks = 0;
  int fails  = 0;

  fetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fetch_ctrl #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .PROG_MAX (PMAX)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .bus            (bus),
    .prog_len       (prog_len),
    .busy           (busy),
    .done           (done),
    .err            (err)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_run_cyc   (perf_run_cyc),
    .perf_stall_cyc (perf_stall_cyc)
`endif
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value and log mismatches
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs just after the clock edge, return at mid-cycle
  task automatic applyStimulus(input logic st, input logic v, input logic [DW-1:0] d,
                               input logic l, input logic hz, input logic br,
                               input logic [AW-1:0] tgt, input logic [AW-1:0] pc);
    @(posedge clk);
    #1;
    start         = st;
    bus.ld_valid  = v;
    bus.ld_data   = d;
    bus.ld_last   = l;
    bus.hz_stall  = hz;
    bus.br_taken  = br;
    bus.br_target = tgt;
    bus.pc_cur    = pc;
    @(negedge clk);
  endtask

  initial begin
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    bus.ld_last   = 1'b0;
    bus.hz_stall  = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_target = '0;
    bus.pc_cur    = '0;

    // Reset state
    #2;
    checkOutput("rst_busy",     busy,           0);
    checkOutput("rst_done",     done,           0);
    checkOutput("rst_err",      err,            0);
    checkOutput("rst_len",      prog_len,       0);
    checkOutput("rst_ready",    bus.ld_ready,   0);
    checkOutput("rst_stall",    bus.if_stall,   0);
    checkOutput("rst_ifrst",    bus.if_rst,     0);
    checkOutput("rst_load_en",  bus.if_load_en, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: load A0..A3, run to pc_cur=2, halt
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_idle_busy", busy, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_clr_ifrst", bus.if_rst, 1);
    checkOutput("t1_clr_stall", bus.if_stall, 1);
    checkOutput("t1_clr_busy",  busy, 1);
    checkOutput("t1_clr_ldre",  bus.if_load_en, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 32'hA0 + i, (i == 3), 0, 0, 0, 0);
      checkOutput("t1_ld_en",    bus.if_load_en, 1);
      checkOutput("t1_ld_instr", bus.if_instr,   32'hA0 + i);
      checkOutput("t1_ld_ifrst", bus.if_rst,     0);
      checkOutput("t1_ld_ready", bus.ld_ready,   1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_run_len",   prog_len, 4);
    checkOutput("t1_run_ready", bus.ld_ready, 0);
    checkOutput("t1_run_stall", bus.if_stall, 0);
    checkOutput("t1_run_busy",  busy, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 2);
    checkOutput("t1_end_done",  done, 0);
    checkOutput("t1_end_stall", bus.if_stall, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 2);
    checkOutput("t1_halt_done",  done, 1);
    checkOutput("t1_halt_stall", bus.if_stall, 1);
    checkOutput("t1_halt_busy",  busy, 0);
    checkOutput("t1_halt_len",   prog_len, 4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_halt_done2",  done, 0);
    checkOutput("t1_halt_stall2", bus.if_stall, 1);

    // 2: ld_valid toggling 1,0,1,0,1 (last on the fifth cycle)
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_clr_len",   prog_len, 0);
    checkOutput("t2_clr_ifrst", bus.if_rst, 1);
    begin
      logic [4:0] vpat;
      int         cnt;
      vpat = 5'b10101;
      cnt  = 0;
      for (int i = 0; i < 5; i++) begin
        applyStimulus(0, vpat[i], 32'hB0 + i, (i == 4), 0, 0, 0, 0);
        checkOutput("t2_ld_en",  bus.if_load_en, vpat[i]);
        checkOutput("t2_ld_len", prog_len, cnt);
        if (vpat[i]) cnt++;
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_run_len",  prog_len, 3);
    checkOutput("t2_run_busy", busy, 1);

    // 3: stalls forwarded, then a branch overrides a stall
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
      checkOutput("t3_stall",   bus.if_stall, 1);
      checkOutput("t3_nobr",    bus.if_branch, 0);
    end
    applyStimulus(0, 0, 0, 0, 1, 1, 10'h010, 0);
    checkOutput("t3_br",       bus.if_branch, 1);
    checkOutput("t3_br_pc",    bus.if_pc_in, 10'h010);
    checkOutput("t3_br_stall", bus.if_stall, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("t3_odd_end_busy", busy, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("t3_odd_done",  done, 1);
    checkOutput("t3_odd_stall", bus.if_stall, 1);

    // 4: branch in the end-of-program cycle suppresses halt; start in RUN ignored
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1, 32'hC0 + i, (i == 3), 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 10'h000, 2);
    checkOutput("t4_br",      bus.if_branch, 1);
    checkOutput("t4_br_pc",   bus.if_pc_in, 0);
    checkOutput("t4_br_stl",  bus.if_stall, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_run_busy", busy, 1);
    checkOutput("t4_run_done", done, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_ign_ifrst", bus.if_rst, 0);
    checkOutput("t4_ign_busy",  busy, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_halt_done", done, 1);

    // 5: nine words into an eight-deep buffer
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 1, 32'hE0 + i, 0, 0, 0, 0, 0);
      checkOutput("t5_ld_en",    bus.if_load_en, (i < 8));
      checkOutput("t5_ld_ready", bus.ld_ready, 1);
    end
    checkOutput("t5_pre_err", err, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t5_done",  done, 1);
    checkOutput("t5_err",   err, 1);
    checkOutput("t5_len",   prog_len, 8);
    checkOutput("t5_busy",  busy, 0);
    checkOutput("t5_stall", bus.if_stall, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t5_err_sticky", err, 1);

    // 6: asynchronous reset in the middle of a load, then reload
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_clr_err", err, 0);
    checkOutput("t6_clr_len", prog_len, 0);
    for (int i = 0; i < 2; i++)
      applyStimulus(0, 1, 32'hF0 + i, 0, 0, 0, 0, 0);
    checkOutput("t6_pre_len", prog_len, 1);
    @(posedge clk);
    #1;
    bus.ld_data = 32'hF2;
    rst_n       = 1'b0;
    #1;
    checkOutput("t6_rst_load_en", bus.if_load_en, 0);
    checkOutput("t6_rst_instr",   bus.if_instr, 0);
    checkOutput("t6_rst_ready",   bus.ld_ready, 0);
    checkOutput("t6_rst_busy",    busy, 0);
    checkOutput("t6_rst_len",     prog_len, 0);
    checkOutput("t6_rst_stall",   bus.if_stall, 0);
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.ld_valid = 1'b0;
    @(negedge clk);
    checkOutput("t6_idle_busy",    busy, 0);
    checkOutput("t6_idle_load_en", bus.if_load_en, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_re_ifrst", bus.if_rst, 1);
    applyStimulus(0, 1, 32'hD0, 1, 0, 0, 0, 0);
    checkOutput("t6_re_en",    bus.if_load_en, 1);
    checkOutput("t6_re_instr", bus.if_instr, 32'hD0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_run_len",  prog_len, 1);
    checkOutput("t6_run_busy", busy, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_halt_done", done, 1);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
